serial_frame_deserializer: RTL

SERIAL_FRAME_DESERIALIZER -- requirements
Module: serial_frame_deserializer

---
 rtl/serial_frame_deserializer_if.sv | 14 +
 rtl/serial_frame_deserializer.sv | 58 +++++
 2 files changed

// File: rtl/serial_frame_deserializer_if.sv
// serial_frame_deserializer_if: serial-in / parallel-out bus of the frame deserializer
// Ports: bit_en, serial_in, out_ready flow into the deserializer; out_valid, out_data,
// frame_err and overrun flow out. The slave modport is the deserializer side.
interface serial_frame_deserializer_if #(parameter int WIDTH = 4);
  logic             bit_en;
  logic             serial_in;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             frame_err;
  logic             overrun;
  modport master (output bit_en, serial_in, out_ready, input out_valid, out_data, frame_err, overrun);
  modport slave  (input bit_en, serial_in, out_ready, output out_valid, out_data, frame_err, overrun);
endinterface

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer: receives start/WIDTH-data(LSB first)/stop frames into a one-word output buffer
// Ports: clk rising-edge clock; reset_n async active-low reset; bus (slave) carries the bit strobe,
// serial line, ready/valid word handshake and the one-cycle frame_err / overrun pulses.
module serial_frame_deserializer #(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset_n,
  serial_frame_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic last, free;
  assign last = cnt == CW'(WIDTH - 1);
  // the buffer may be refilled on the very edge it is drained
  assign free = !bus.out_valid || bus.out_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (bus.bit_en)
      case (state)
        IDLE: state_n = bus.serial_in ? IDLE : DATA;
        DATA: state_n = last ? STOP : DATA;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      sh <= '0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (bus.bit_en)
        case (state)
          IDLE: if (!bus.serial_in) cnt <= '0;
          DATA: begin
            sh <= {bus.serial_in, sh[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
          end
          STOP:
            if (!bus.serial_in) bus.frame_err <= 1'b1;
            else if (free) begin
              bus.out_data <= sh;
              bus.out_valid <= 1'b1;
            end else bus.overrun <= 1'b1;
          default: ;
        endcase
    end
endmodule
